// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU (alu_seq) and its multiply engine.
//   - 3-bit opcode constants OP_AND .. OP_MUL
//   - control state enum IDLE / MUL / DONE
//   - packed flag bundle returned alongside every result
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic c_out;
        logic overflow;
        logic lt;
        logic eq;
        logic gt;
        logic zero;
    } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// -----------------------------------------------------------------------------
// alu_seq_mul
// Iterative unsigned shift-add multiplier, one partial product per clock.
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset (aborts any multiply in flight)
//   start  in   load operands, clear accumulator, begin WIDTH iterations
//   x      in   multiplicand
//   y      in   multiplier
//   done   out  high while the full 2*WIDTH-bit product is available
//   prod   out  accumulator (full product once done is high)
// done is asserted the cycle after the last iteration and drops one cycle
// later; the parent captures the product in that cycle.
// -----------------------------------------------------------------------------
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH + 1);

    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               w_step;

    assign w_step = r_busy && (r_cnt != '0);

    // Control: iteration counter and busy flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(WIDTH);
        end else if (w_step) begin
            r_cnt  <= r_cnt - CW'(1);
        end else if (r_busy) begin
            r_busy <= 1'b0;
        end
    end

    // Datapath: accumulate, then shift multiplicand left and multiplier right
    always_ff @(posedge clk) begin
        if (start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, x};
            r_mplier <= y;
        end else if (w_step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign done = r_busy && (r_cnt == '0);
    assign prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Registered ALU with valid/ready handshakes on both sides. Logic ops, add,
// subtract, set-less-than and shifts complete one cycle after accept; MUL runs
// on the iterative engine and completes WIDTH+1 cycles after accept.
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   in_valid / in_ready     input handshake; in_ready is high only in IDLE
//   x, y, c_in, op          operands, carry in (ADD only), opcode
//   out_valid / out_ready   output handshake; result held while stalled
//   z                       result
//   c_out, overflow         carry (ADD/SUB) and signed/product overflow
//   lt, eq, gt              unsigned compare of the accepted x, y
//   zero                    z == 0
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int  WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             c_out,
    output logic             overflow,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             zero
);

    state_t             r_state;
    state_t             w_next;
    flags_t             r_flags;
    logic [WIDTH-1:0]   r_z;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;

    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_alu_z;
    logic               w_alu_c;
    logic               w_alu_ov;

    // Packs the flag bundle; compares are always on the operands of this op.
    function automatic flags_t make_flags(
        input logic             c,
        input logic             ov,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] res
    );
        flags_t f;
        f.c_out    = c;
        f.overflow = ov;
        f.lt       = (a < b);
        f.eq       = (a == b);
        f.gt       = (a > b);
        f.zero     = (res == '0);
        return f;
    endfunction

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_mul_start = w_accept && (op == OP_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_mul_start),
        .x     (x),
        .y     (y),
        .done  (w_mul_done),
        .prod  (w_mul_prod)
    );

    // Single-cycle ops straight from the input operands
    always_comb begin
        w_sum    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c_in};
        // Two's-complement subtract: carry out high means no borrow
        w_diff   = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        w_alu_z  = '0;
        w_alu_c  = 1'b0;
        w_alu_ov = 1'b0;
        case (op)
            OP_AND: w_alu_z = x & y;
            OP_OR:  w_alu_z = x | y;
            OP_ADD: begin
                w_alu_z  = w_sum[WIDTH-1:0];
                w_alu_c  = w_sum[WIDTH];
                w_alu_ov = (x[WIDTH-1] == y[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_z  = w_diff[WIDTH-1:0];
                w_alu_c  = w_diff[WIDTH];
                w_alu_ov = (x[WIDTH-1] != y[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SLT: w_alu_z = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_SLL: w_alu_z = x << y[SHW-1:0];
            OP_SRL: w_alu_z = x >> y[SHW-1:0];
            default: w_alu_z = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = (op == OP_MUL) ? MUL : DONE;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture for the MUL compare flags
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x <= x;
            r_y <= y;
        end
    end

    // Result and flag registers; only written on completion, so a stalled
    // beat in DONE holds them unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_z     <= '0;
            r_flags <= '0;
        end else if (w_accept && (op != OP_MUL)) begin
            r_z     <= w_alu_z;
            r_flags <= make_flags(w_alu_c, w_alu_ov, x, y, w_alu_z);
        end else if ((r_state == MUL) && w_mul_done) begin
            r_z     <= w_mul_prod[WIDTH-1:0];
            r_flags <= make_flags(1'b0, |w_mul_prod[2*WIDTH-1:WIDTH], r_x, r_y,
                                  w_mul_prod[WIDTH-1:0]);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign z         = r_z;
    assign c_out     = r_flags.c_out;
    assign overflow  = r_flags.overflow;
    assign lt        = r_flags.lt;
    assign eq        = r_flags.eq;
    assign gt        = r_flags.gt;
    assign zero      = r_flags.zero;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the team's 16-bit combinational ALU. Operand width is generalised.
- Adds shifts and an iterative shift-add multiply.
- Uses valid/ready handshakes on input and output, so it can sit in a pipelined datapath with backpressure.
- Flags (carry, signed overflow, compare, zero) are registered with the result and returned in the same beat.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept an operation.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B (shift amount = y[SHW-1:0]).
- c_in  in  1  carry in (ADD only).
- op  in  3  operation select.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- z  out  WIDTH  result.
- c_out, overflow, lt, eq, gt, zero  out  1 each  flags.

Behaviour:
- Reset:
  - rst_n low at a clk edge gives state IDLE, in_ready=1 on the following cycle, out_valid=0, and z and all flags 0.
  - Reset mid-multiply or mid-hold discards the operation; no output beat is produced.
- Opcodes:
  - 0 AND: z = x&y.
  - 1 OR: z = x|y.
  - 2 ADD: {c_out,z} = x+y+c_in.
  - 3 SUB: {c_out,z} = x + ~y + 1, so c_out=1 means no borrow (x ≥ y unsigned).
  - 4 SLT: z = zero-extended (x<y unsigned).
  - 5 SLL: z = x << y[SHW-1:0].
  - 6 SRL: logical right shift by y[SHW-1:0].
  - 7 MUL: z = low WIDTH bits of x*y, unsigned.
- Overflow:
  - ADD: signed overflow = (x[MSB]==y[MSB]) && (z[MSB]!=x[MSB]).
  - SUB: overflow = (x[MSB]!=y[MSB]) && (z[MSB]!=x[MSB]).
  - MUL: overflow = 1 if the high half of the product is nonzero.
  - All other ops: overflow=0.
- c_out is 0 for every op other than ADD and SUB.
- lt/eq/gt are the unsigned comparison of the captured x,y, produced for every op.
- zero = (z == 0), for every op.
- Handshake:
  - Accept happens on a clk edge where in_valid && in_ready; the block registers x, y, c_in, op.
  - in_ready is 1 only in IDLE.
  - A result beat completes on an edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, z and all flags are held stable.
- States:
  - IDLE:
    - An accept with a non-MUL op computes the result into the output registers and moves to DONE, so out_valid=1 the cycle after the accept (latency 1).
    - An accept with op=MUL clears the accumulator, loads multiplicand/multiplier and count=WIDTH, and moves to MUL.
  - MUL:
    - Each cycle: if multiplier[0], acc += multiplicand (2*WIDTH-bit acc). Then multiplicand <<= 1, multiplier >>= 1, count--.
    - When count reaches 0, write z and flags and move to DONE.
    - out_valid rises WIDTH+1 cycles after the accept; in_ready=0 throughout.
  - DONE:
    - out_valid=1. If out_ready, go to IDLE (in_ready=1 the next cycle).
    - No accept occurs in the cycle the result drains (no bypass), so the maximum throughput is one op per 2 cycles.
- Boundary conditions:
  - Shift amount 0 passes x through unchanged; shift amount ≥ WIDTH is impossible by truncation.
  - MUL by 0 gives z=0, zero=1, overflow=0.
  - in_valid with an unchanged op during MUL or DONE is ignored; the source must hold its data until in_ready.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_AND..OP_MUL (3-bit);
  - the state enum IDLE/MUL/DONE;
  - a flag-bundle struct {c_out, overflow, lt, eq, gt, zero}.
- One sub-module, alu_seq_mul: the iterative shift-add engine.
  - Ports: start, x, y → done, prod[2*WIDTH-1:0].
  - Lives under the alu_seq top level.
- Combinational ops and flag generation stay in the top level.

Test Plan (WIDTH=16):
- ADD with carry: x=0x0100, y=0x000F, c_in=1, op=2 → one cycle later z=0x0110, c_out=0, overflow=0, gt=1. Then x=0x7FFF, y=0x0001, c_in=0 → z=0x8000, overflow=1.
- SUB borrow and zero:
  - x=0x0005, y=0x0005, op=3 → z=0, zero=1, eq=1, c_out=1.
  - x=0x0001, y=0x000F → z=0xFFF2, c_out=0, lt=1.
- Shifts and SLT:
  - x=0x8001, y=0x0004, op=6 → z=0x0800.
  - op=5 with y=0x0010 (amount 0) → z=0x8001.
  - x=1, y=15, op=4 → z=0x0001.
- MUL latency and overflow:
  - x=0x00FF, y=0x0101, op=7 → out_valid exactly 17 cycles after the accept, z=0xFFFF, overflow=0.
  - x=0x1000, y=0x0010 → z=0, zero=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → z and flags are stable, in_ready=0, and in_valid pulses are ignored. Release → beat completes and in_ready=1 the next cycle.
- Reset mid-MUL: assert rst_n=0 eight cycles into a MUL → the next cycle out_valid=0, z=0, in_ready=1, and no stale result appears afterwards.
